// File: rtl/mbist_bg_pkg.sv
// Shared types and constants for the MBIST data-background sequencer.
// Holds the sequencer state encoding, the base background indices and the background count.
package mbist_bg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bg_state_e;

  localparam int BG_CHK      = 0;
  localparam int BG_CHK_N    = 1;
  localparam int BG_HI       = 2;
  localparam int BG_LO       = 3;
  localparam int BG_ZERO     = 4;
  localparam int BG_ONE      = 5;
  localparam int BG_WALK1    = 6;
  localparam int NUM_BASE_BG = 6;

  // The walking backgrounds contribute one walking-1 and one walking-0 word per data bit.
  function automatic int calc_num_bg(input int data_w, input bit walk_en);
    return NUM_BASE_BG + (walk_en ? 2 * data_w : 0);
  endfunction

endpackage

// File: rtl/mbist_bg_pattern.sv
// Combinational background decoder: maps a background index to its DATA_W-bit word.
// Any index outside the background map decodes to all zeros, so the output is never X.
module mbist_bg_pattern
  import mbist_bg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
) (
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] pat_o
);

  localparam int BG_WALK0 = BG_WALK1 + DATA_W;
  localparam int BG_END   = BG_WALK1 + 2 * DATA_W;

  int idx_int;
  assign idx_int = int'(idx_i);

  // Each output bit is decoded independently from the index.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    assign pat_o[gi] = ((idx_int == BG_CHK)   && (gi % 2 == 1))
                    || ((idx_int == BG_CHK_N) && (gi % 2 == 0))
                    || ((idx_int == BG_HI)    && (gi >= DATA_W / 2))
                    || ((idx_int == BG_LO)    && (gi <  DATA_W / 2))
                    ||  (idx_int == BG_ONE)
                    ||  (idx_int == BG_WALK1 + gi)
                    || ((idx_int >= BG_WALK0) && (idx_int < BG_END)
                        && (idx_int != BG_WALK0 + gi));
  end

endmodule

// File: rtl/mbist_bg_seq.sv
// MBIST data-background sequencer: steps through the background map under a start/advance
// handshake, either sweeping every background or presenting one selected background.
module mbist_bg_seq
  import mbist_bg_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int WALK_EN = 1,
  parameter int NUM_BG  = calc_num_bg(DATA_W, WALK_EN != 0),
  parameter int IDX_W   = $clog2(NUM_BG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [IDX_W-1:0]  sel,
  input  logic              adv,
  input  logic              abort,
  output logic [DATA_W-1:0] bg_data,
  output logic [DATA_W-1:0] bg_data_n,
  output logic [IDX_W-1:0]  bg_idx,
  output logic              bg_valid,
  output logic              bg_last,
  output logic              done,
  output logic              err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BG - 1);

  bg_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] pat;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              load_pat;

  // Decode the next index so the pattern lands in the register together with it.
  mbist_bg_pattern #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_pattern (
    .idx_i (idx_d),
    .pat_o (pat)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load_pat = 1'b0;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!mode) begin
              idx_d    = '0;
              load_pat = 1'b1;
              valid_d  = 1'b1;
              last_d   = 1'b0;
              state_d  = RUN;
            end else if (sel <= LAST_IDX) begin
              idx_d    = sel;
              load_pat = 1'b1;
              valid_d  = 1'b1;
              last_d   = 1'b1;
              state_d  = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (adv) begin
            if (last_q) begin
              state_d = DONE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              // last_q stays low in a sweep until LAST_IDX, so this never wraps.
              idx_d    = idx_q + IDX_W'(1);
              load_pat = 1'b1;
              last_d   = (idx_d == LAST_IDX);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (load_pat) begin
        data_q <= pat;
      end
    end
  end

  assign bg_data   = data_q;
  assign bg_data_n = ~data_q;
  assign bg_idx    = idx_q;
  assign bg_valid  = valid_q;
  assign bg_last   = last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mbist_bg_seq.sv
// Bench for mbist_bg_seq: an 8-bit walking-enabled instance and a 16-bit base-only instance
// run side by side against a reference model of the background sequence.
module tb_mbist_bg_seq;

  localparam int W8  = 8;
  localparam int N8  = 22;
  localparam int W16 = 16;
  localparam int N16 = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        start8, mode8, adv8, abort8;
  logic [4:0]  sel8;
  logic [7:0]  bg_data8, bg_data_n8;
  logic [4:0]  bg_idx8;
  logic        bg_valid8, bg_last8, done8, err8;

  logic        start16, mode16, adv16, abort16;
  logic [2:0]  sel16;
  logic [15:0] bg_data16, bg_data_n16;
  logic [2:0]  bg_idx16;
  logic        bg_valid16, bg_last16, done16, err16;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: phase 0 idle, 1 running, 2 finishing.
  int          m_phase  [2];
  int          m_idx    [2];
  bit          m_single [2];
  bit          m_done   [2];
  bit          m_err    [2];
  logic [15:0] m_data   [2];

  always #5 clk = ~clk;

  mbist_bg_seq #(.DATA_W(W8), .WALK_EN(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .sel(sel8), .adv(adv8),
    .abort(abort8), .bg_data(bg_data8), .bg_data_n(bg_data_n8), .bg_idx(bg_idx8),
    .bg_valid(bg_valid8), .bg_last(bg_last8), .done(done8), .err(err8)
  );

  mbist_bg_seq #(.DATA_W(W16), .WALK_EN(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .sel(sel16), .adv(adv16),
    .abort(abort16), .bg_data(bg_data16), .bg_data_n(bg_data_n16), .bg_idx(bg_idx16),
    .bg_valid(bg_valid16), .bg_last(bg_last16), .done(done16), .err(err16)
  );

  function automatic logic [15:0] ref_pat(input int w, input int idx);
    logic [15:0] p;
    p = '0;
    for (int b = 0; b < w; b++) begin
      case (idx)
        0: p[b] = (b % 2 == 1);
        1: p[b] = (b % 2 == 0);
        2: p[b] = (b >= w / 2);
        3: p[b] = (b < w / 2);
        4: p[b] = 1'b0;
        5: p[b] = 1'b1;
        default: begin
          if (idx < 6 + w) p[b] = (b == idx - 6);
          else             p[b] = (b != idx - 6 - w);
        end
      endcase
    end
    return p;
  endfunction

  function automatic logic [15:0] mask(input int w);
    return (w == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_idx[d] = 0; m_single[d] = 0;
      m_done[d] = 0; m_err[d] = 0; m_data[d] = '0;
    end
  endtask

  task automatic model_step(input int d, input int w, input int n, input bit st, input bit md,
                            input int sl, input bit ad, input bit ab);
    m_done[d] = 0;
    m_err[d]  = 0;
    if (ab) begin
      m_phase[d] = 0;
    end else begin
      case (m_phase[d])
        0: if (st) begin
          if (!md) begin
            m_idx[d] = 0; m_single[d] = 0; m_phase[d] = 1;
          end else if (sl < n) begin
            m_idx[d] = sl; m_single[d] = 1; m_phase[d] = 1;
          end else begin
            m_err[d] = 1;
          end
        end
        1: if (ad) begin
          if (m_single[d] || m_idx[d] == n - 1) begin
            m_phase[d] = 2; m_done[d] = 1;
          end else begin
            m_idx[d] = m_idx[d] + 1;
          end
        end
        default: m_phase[d] = 0;
      endcase
    end
    if (m_phase[d] == 1) m_data[d] = ref_pat(w, m_idx[d]);
  endtask

  task automatic check_dut(input int d, input int n, input logic [15:0] data, input logic [15:0] data_n,
                           input int idx, input logic valid, input logic last, input logic dn,
                           input logic er, input int w);
    logic exp_last;
    exp_last = (m_phase[d] == 1) && (m_single[d] || m_idx[d] == n - 1);
    chk("bg_data",   d, 32'(data),   32'(m_data[d] & mask(w)));
    chk("bg_data_n", d, 32'(data_n), 32'(~m_data[d] & mask(w)));
    chk("bg_idx",    d, 32'(idx),    32'(m_idx[d]));
    chk("bg_valid",  d, 32'(valid),  32'(m_phase[d] == 1));
    chk("bg_last",   d, 32'(last),   32'(exp_last));
    chk("done",      d, 32'(dn),     32'(m_done[d]));
    chk("err",       d, 32'(er),     32'(m_err[d]));
  endtask

  task automatic check_all();
    check_dut(0, N8, 16'(bg_data8), 16'(bg_data_n8), int'(bg_idx8), bg_valid8, bg_last8,
              done8, err8, W8);
    check_dut(1, N16, bg_data16, bg_data_n16, int'(bg_idx16), bg_valid16, bg_last16,
              done16, err16, W16);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, W8, N8, start8, mode8, int'(sel8), adv8, abort8);
      model_step(1, W16, N16, start16, mode16, int'(sel16), adv16, abort16);
    end
    #1;
    check_all();
  endtask

  task automatic set8(input bit st, input bit md, input int sl, input bit ad, input bit ab);
    start8 = st; mode8 = md; sel8 = 5'(sl); adv8 = ad; abort8 = ab;
  endtask

  task automatic set16(input bit st, input bit md, input int sl, input bit ad, input bit ab);
    start16 = st; mode16 = md; sel16 = 3'(sl); adv16 = ad; abort16 = ab;
  endtask

  initial begin
    set8(0, 0, 0, 0, 0);
    set16(0, 0, 0, 0, 0);
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Full sweep on both instances; adv keeps going into IDLE where it must be ignored.
    set8(1, 0, 0, 0, 0);
    set16(1, 0, 0, 0, 0);
    tick();
    chk("first_bg_8", 0, 32'(bg_data8), 32'h0000_00AA);
    chk("first_bg_16", 1, 32'(bg_data16), 32'h0000_AAAA);
    set8(0, 0, 0, 1, 0);
    set16(0, 0, 0, 1, 0);
    repeat (N8 + 2) tick();
    set8(0, 0, 0, 0, 0);
    set16(0, 0, 0, 0, 0);
    tick();

    // Single background, then an illegal selection on each instance.
    set8(1, 1, 3, 0, 0);
    set16(1, 1, 6, 0, 0);
    tick();
    chk("single_sel3", 0, 32'(bg_data8), 32'h0000_000F);
    set8(0, 0, 0, 1, 0);
    set16(0, 0, 0, 0, 0);
    tick();
    tick();
    set8(1, 1, 22, 0, 0);
    set16(1, 1, 4, 0, 0);
    tick();
    set8(0, 0, 0, 0, 0);
    set16(0, 0, 0, 1, 0);
    tick();
    tick();

    // Abort together with adv at idx9, then restart from idx0; start in RUN is ignored.
    set8(1, 0, 0, 0, 0);
    tick();
    set8(0, 0, 0, 1, 0);
    repeat (9) tick();
    set8(1, 1, 7, 1, 1);
    tick();
    set8(0, 0, 0, 0, 0);
    tick();
    set8(1, 0, 0, 0, 0);
    tick();
    chk("restart_bg", 0, 32'(bg_data8), 32'h0000_00AA);
    set8(1, 1, 7, 1, 0);
    tick();
    set8(0, 0, 0, 1, 0);
    repeat (3) tick();

    // Asynchronous reset between clock edges at idx4.
    set8(0, 0, 0, 0, 0);
    set16(1, 0, 0, 0, 0);
    tick();
    set16(0, 0, 0, 1, 0);
    repeat (4) tick();
    set16(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Random traffic on both instances, with rare aborts and illegal selections.
    for (int i = 0; i < 400; i++) begin
      set8(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      set16(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
